mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Controls the single shared 8-bit instruction/data memory of the pipelined CPU.
- Arbitrates each cycle between the IF-stage fetch port and the MEM-stage data port (load/store/push/pop), and raises stall_if when a fetch loses.
- Sequences the reset-vector fetch after reset and the interrupt-vector fetch on int_sig.
- Delivers each fetched vector to the PC loader on vec_valid/vec_data.

Parameters:
AW, 8, memory address width
DW, 8, memory data width
STARVE_MAX, 3, consecutive lost if_req cycles after which fetch wins over data (range 1..15)
RST_VEC_ADDR, 8'h00, address holding the reset vector
INT_VEC_ADDR, 8'h01, address holding the interrupt vector

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  reset, asynchronous, active-high
if_req  in  1  fetch request
if_addr  in  AW  fetch address (PC)
if_gnt  out  1  fetch granted this cycle (combinational)
if_rvalid  out  1  fetch data valid on if_rdata (registered)
if_rdata  out  DW  fetch data (= mem_rdata)
dm_req  in  1  data request
dm_we  in  1  1 = write, 0 = read
dm_addr  in  AW  data address
dm_wdata  in  DW  write data
dm_gnt  out  1  data granted this cycle (combinational)
dm_rvalid  out  1  read data valid on dm_rdata (registered)
dm_rdata  out  DW  read data (= mem_rdata)
stall_if  out  1  if_req && !if_gnt
int_sig  in  1  external interrupt, level input, rising-edge sensitive
vec_valid  out  1  one-cycle pulse, vec_data holds a new PC
vec_data  out  DW  fetched vector (registered)
mem_addr  out  AW  memory address
mem_we  out  1  memory write enable
mem_wdata  out  DW  memory write data (= dm_wdata)
mem_rdata  in  DW  memory read data, synchronous: valid the cycle after the address is presented

Behaviour:
- Reset (async, immediate):
  - state = BOOT; starve_cnt = 0; int_pend = 0; int_sig_d = 0.
  - if_gnt, dm_gnt, if_rvalid, dm_rvalid, vec_valid, mem_we and stall_if are 0.
  - vec_data = 0; mem_addr = 0.
- FSM states: BOOT, BOOT_WAIT, RUN, INT_VEC, INT_WAIT.
  - BOOT: mem_addr = RST_VEC_ADDR, read; no grants; stall_if = if_req; -> BOOT_WAIT.
  - BOOT_WAIT: vec_data <= mem_rdata, vec_valid pulses the next cycle; no grants; -> RUN.
  - RUN: per-cycle arbitration (below). If int_pend and !dm_req -> INT_VEC, and that cycle grants nothing.
  - INT_VEC: mem_addr = INT_VEC_ADDR, read; no grants; -> INT_WAIT.
  - INT_WAIT: vec_data <= mem_rdata, vec_valid pulses the next cycle; int_pend cleared; no grants; -> RUN.
- Interrupt latch:
  - int_sig_d registers int_sig; an edge is int_sig && !int_sig_d, and it sets int_pend.
  - Sticky: multiple edges before service merge into one.
  - An edge in the same cycle as the INT_WAIT clear wins: int_pend stays 1.
  - An in-flight data op is never preempted; the interrupt waits for a cycle with dm_req = 0.
- RUN arbitration (no pending interrupt taken):
  - force_if = if_req && (starve_cnt == STARVE_MAX).
  - dm_gnt = dm_req && !force_if.
  - if_gnt = if_req && (!dm_req || force_if).
  - mem_addr = dm_addr when dm_gnt, else if_addr. mem_we = dm_gnt && dm_we.
- Starvation counter (4-bit):
  - Increments when if_req && dm_gnt; saturates at STARVE_MAX.
  - Clears to 0 when if_gnt or !if_req.
- Read return:
  - if_rvalid <= if_gnt.
  - dm_rvalid <= dm_gnt && !dm_we.
  - Latency is exactly 1 cycle after the grant; writes never return rvalid.
  - Vector fetches never assert if_rvalid or dm_rvalid.
- Requesters hold req/addr/wdata stable until granted; the arbiter does not queue.
- Reset mid-operation (any state) aborts the fetch: no vec_valid, and the FSM restarts at BOOT.

Test Plan:
1. Release rst with mem[0] = 8'h10 and if_req = 1 -> BOOT and BOOT_WAIT with if_gnt = 0 and stall_if = 1; vec_valid = 1 for one cycle with vec_data = 8'h10 on the 3rd clock; if_gnt = 1 in RUN.
2. In RUN, if_req = dm_req = 1, dm_we = 0, dm_addr = 8'h20, mem[0x20] = 8'hAB for 2 cycles -> dm_gnt = 1, stall_if = 1, mem_addr = 8'h20; dm_rvalid = 1 with dm_rdata = 8'hAB on the following cycle; if_rvalid stays 0.
3. Hold dm_req = 1 and if_req = 1 continuously, STARVE_MAX = 3 -> pattern dm, dm, dm, if, dm, dm, dm, if ...; starve_cnt resets after each fetch grant.
4. dm_req = 1, dm_we = 1, dm_addr = 8'h30, dm_wdata = 8'h5A -> mem_we = 1 for one cycle and mem[0x30] = 8'h5A; dm_rvalid stays 0.
5. mem[1] = 8'h40, pulse int_sig while dm_req = 1 for 2 cycles -> no vector fetch while dm_req = 1; after dm_req drops: INT_VEC with mem_addr = 8'h01, then vec_valid with vec_data = 8'h40; a second int_sig edge during INT_VEC causes exactly one further vector fetch.
6. Assert rst during INT_WAIT -> all outputs 0 immediately, no vec_valid; after release the reset vector is re-fetched and int_pend = 0.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: CPU-side fetch and data ports of the shared memory arbiter.
interface mem_port_arbiter_if #(
    parameter int AW = 8,
    parameter int DW = 8
);
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_gnt;
    logic          if_rvalid;
    logic [DW-1:0] if_rdata;
    logic          dm_req;
    logic          dm_we;
    logic [AW-1:0] dm_addr;
    logic [DW-1:0] dm_wdata;
    logic          dm_gnt;
    logic          dm_rvalid;
    logic [DW-1:0] dm_rdata;
    logic          stall_if;
    modport master (
        output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata,
        input  if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata, stall_if
    );
    modport slave (
        input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata,
        output if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata, stall_if
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shared instruction/data memory arbiter with reset/interrupt vector sequencing.
// The data port wins by default; a fetch that has lost STARVE_MAX cycles in a row is forced through.
module mem_port_arbiter #(
    parameter int            AW           = 8,
    parameter int            DW           = 8,
    parameter int            STARVE_MAX   = 3,
    parameter logic [AW-1:0] RST_VEC_ADDR = 8'h00,
    parameter logic [AW-1:0] INT_VEC_ADDR = 8'h01
) (
    input  logic              clk,
    input  logic              rst,
    mem_port_arbiter_if.slave cpu,
    input  logic              int_sig,
    output logic              vec_valid,
    output logic [DW-1:0]     vec_data,
    output logic [AW-1:0]     mem_addr,
    output logic              mem_we,
    output logic [DW-1:0]     mem_wdata,
    input  logic [DW-1:0]     mem_rdata
);
    localparam logic [2:0] BOOT = 3'd0, BOOT_WAIT = 3'd1, RUN = 3'd2, INT_VEC = 3'd3, INT_WAIT = 3'd4;
    localparam logic [3:0] SMAX = 4'(STARVE_MAX);

    logic [2:0]    state_q, state_d;
    logic [3:0]    starve_q, starve_d;
    logic          int_pend_q, int_pend_d, int_rearm_q, int_rearm_d, int_dly_q, int_dly_d;
    logic          if_rvalid_q, if_rvalid_d, dm_rvalid_q, dm_rvalid_d, vec_valid_q, vec_valid_d;
    logic [DW-1:0] vec_data_q, vec_data_d;
    logic          int_edge, take, force_if, if_gnt, dm_gnt, cap;

    always_comb begin
        int_edge    = int_sig && !int_dly_q;
        take        = state_q == RUN && int_pend_q && !cpu.dm_req;
        force_if    = cpu.if_req && starve_q == SMAX;
        dm_gnt      = state_q == RUN && cpu.dm_req && !force_if;
        if_gnt      = state_q == RUN && !take && cpu.if_req && (!cpu.dm_req || force_if);
        cap         = state_q == BOOT_WAIT || state_q == INT_WAIT;
        state_d     = state_q == BOOT ? BOOT_WAIT : state_q == INT_VEC ? INT_WAIT : take ? INT_VEC : RUN;
        starve_d    = (!cpu.if_req || if_gnt) ? 4'd0 :
                      (dm_gnt && starve_q != SMAX) ? starve_q + 4'd1 : starve_q;
        int_dly_d   = int_sig;
        // an edge arriving while the vector is being fetched must survive the INT_WAIT clear
        int_rearm_d = state_q == INT_VEC && int_edge;
        int_pend_d  = int_edge || (state_q == INT_WAIT ? int_rearm_q : int_pend_q);
        if_rvalid_d = if_gnt;
        dm_rvalid_d = dm_gnt && !cpu.dm_we;
        vec_valid_d = cap;
        vec_data_d  = cap ? mem_rdata : vec_data_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= BOOT;
            starve_q    <= '0;
            int_pend_q  <= 1'b0;
            int_rearm_q <= 1'b0;
            int_dly_q   <= 1'b0;
            if_rvalid_q <= 1'b0;
            dm_rvalid_q <= 1'b0;
            vec_valid_q <= 1'b0;
            vec_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            starve_q    <= starve_d;
            int_pend_q  <= int_pend_d;
            int_rearm_q <= int_rearm_d;
            int_dly_q   <= int_dly_d;
            if_rvalid_q <= if_rvalid_d;
            dm_rvalid_q <= dm_rvalid_d;
            vec_valid_q <= vec_valid_d;
            vec_data_q  <= vec_data_d;
        end
    end

    assign cpu.if_gnt    = if_gnt;
    assign cpu.dm_gnt    = dm_gnt;
    assign cpu.stall_if  = cpu.if_req && !if_gnt && !rst;
    assign cpu.if_rvalid = if_rvalid_q;
    assign cpu.dm_rvalid = dm_rvalid_q;
    assign cpu.if_rdata  = mem_rdata;
    assign cpu.dm_rdata  = mem_rdata;
    assign vec_valid     = vec_valid_q;
    assign vec_data      = vec_data_q;
    assign mem_we        = dm_gnt && cpu.dm_we;
    assign mem_wdata     = cpu.dm_wdata;
    assign mem_addr      = rst ? '0 : state_q == BOOT ? RST_VEC_ADDR : state_q == INT_VEC ? INT_VEC_ADDR :
                           dm_gnt ? cpu.dm_addr : cpu.if_addr;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed scenarios plus randomized traffic against a cycle-level reference model.
module tb_mem_port_arbiter;
    localparam int SM = 3;
    logic       clk = 1'b0, rst = 1'b1;
    logic       int_sig = 1'b0, vec_valid, mem_we;
    logic [7:0] vec_data, mem_addr, mem_wdata, mem_rdata;
    logic [7:0] mem [256];
    int         passed = 0, total = 0;

    // reference model state: vector sequence countdown, consecutive fetch losses, interrupt bookkeeping
    int         steps, lost;
    bit         vint, pend, rearm, prev_int;
    bit         e_ig, e_dg, e_stall, e_we, e_take, e_achk;
    logic [7:0] e_addr;
    bit         r_ifv, r_dmv, r_vv;
    logic [7:0] r_vd, r_ifd, r_dmd, v_next;

    mem_port_arbiter_if #(.AW(8), .DW(8)) cpu ();

    mem_port_arbiter #(.AW(8), .DW(8), .STARVE_MAX(SM), .RST_VEC_ADDR(8'h00), .INT_VEC_ADDR(8'h01)) dut (
        .clk(clk), .rst(rst), .cpu(cpu), .int_sig(int_sig), .vec_valid(vec_valid), .vec_data(vec_data),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst)
            for (int i = 0; i < 256; i++)
                mem[i] <= (i == 0) ? 8'h10 : (i == 1) ? 8'h40 : (i == 32) ? 8'hAB : 8'(i * 37 + 11);
        else if (mem_we)
            mem[mem_addr] <= mem_wdata;
        mem_rdata <= mem[mem_addr];
    end

    task automatic model_reset();
        steps = 2; vint = 0; pend = 0; rearm = 0; prev_int = 0; lost = 0;
        r_ifv = 0; r_dmv = 0; r_vv = 0; r_vd = 8'h00; r_ifd = 8'h00; r_dmd = 8'h00; v_next = 8'h00;
    endtask

    task automatic model_comb();
        e_take = 0; e_ig = 0; e_dg = 0; e_we = 0; e_achk = 0; e_addr = 8'h00;
        if (steps == 2) begin
            e_achk = 1;
            e_addr = vint ? 8'h01 : 8'h00;
        end else if (steps == 0 && pend && !cpu.dm_req) begin
            e_take = 1;
        end else if (steps == 0) begin
            e_dg   = cpu.dm_req && !(cpu.if_req && lost >= SM);
            e_ig   = cpu.if_req && !e_dg;
            e_we   = e_dg && cpu.dm_we;
            e_achk = e_dg || e_ig;
            e_addr = e_dg ? cpu.dm_addr : cpu.if_addr;
        end
        e_stall = cpu.if_req && !e_ig;
    endtask

    task automatic model_next();
        bit ed, pn;
        ed = int_sig && !prev_int;
        r_ifv = e_ig; r_ifd = mem[e_addr];
        r_dmv = e_dg && !cpu.dm_we; r_dmd = mem[e_addr];
        r_vv = steps == 1;
        if (steps == 2) v_next = mem[e_addr];
        if (steps == 1) r_vd = v_next;
        lost = (!cpu.if_req || e_ig) ? 0 : (e_dg && lost < SM) ? lost + 1 : lost;
        pn = ed || ((steps == 1 && vint) ? rearm : pend);
        rearm = steps == 2 && vint && ed;
        pend = pn; prev_int = int_sig;
        if (steps > 0) steps--;
        else if (e_take) begin steps = 2; vint = 1; end
    endtask

    task automatic drive(input bit ir, input logic [7:0] ia, input bit dr, input bit dw,
                         input logic [7:0] da, input logic [7:0] dd, input bit is);
        @(negedge clk);
        cpu.if_req = ir; cpu.if_addr = ia; cpu.dm_req = dr; cpu.dm_we = dw;
        cpu.dm_addr = da; cpu.dm_wdata = dd; int_sig = is;
        #1 model_comb();
    endtask

    function automatic logic [47:0] obs();
        return {cpu.if_gnt, cpu.dm_gnt, cpu.stall_if, mem_we, cpu.if_rvalid, cpu.dm_rvalid, vec_valid, 1'b0,
                vec_data, e_achk ? mem_addr : 8'h00, e_we ? mem_wdata : 8'h00,
                r_ifv ? cpu.if_rdata : 8'h00, r_dmv ? cpu.dm_rdata : 8'h00};
    endfunction

    function automatic logic [47:0] expv();
        return {e_ig, e_dg, e_stall, e_we, r_ifv, r_dmv, r_vv, 1'b0,
                r_vd, e_achk ? e_addr : 8'h00, e_we ? cpu.dm_wdata : 8'h00,
                r_ifv ? r_ifd : 8'h00, r_dmv ? r_dmd : 8'h00};
    endfunction

    task automatic test_reset();
        cpu.if_req = 1; cpu.if_addr = 8'h80; cpu.dm_req = 0; cpu.dm_we = 0;
        cpu.dm_addr = 8'h00; cpu.dm_wdata = 8'h00; int_sig = 0;
        model_reset();
        @(negedge clk); #1;
        total++;
        if ({cpu.if_gnt, cpu.dm_gnt, cpu.stall_if, mem_we, cpu.if_rvalid, cpu.dm_rvalid, vec_valid, vec_data, mem_addr} !== 23'h0)
            $display("FAIL reset_outputs got %h want 0", {cpu.if_gnt, cpu.dm_gnt, cpu.stall_if, mem_we, cpu.if_rvalid,
                     cpu.dm_rvalid, vec_valid, vec_data, mem_addr});
        else passed++;
        @(posedge clk); #1 rst = 0;
        for (int i = 0; i < 3; i++) begin
            drive(1, 8'h80, 0, 0, 8'h00, 8'h00, 0);
            total++;
            if (obs() !== expv()) $display("FAIL boot_seq cyc %0d got %h want %h", i, obs(), expv());
            else passed++;
            model_next();
        end
        total++;
        if ({vec_valid, vec_data, cpu.if_gnt} !== {1'b1, 8'h10, 1'b1})
            $display("FAIL boot_vector got %h want %h", {vec_valid, vec_data, cpu.if_gnt}, {1'b1, 8'h10, 1'b1});
        else passed++;
    endtask

    task automatic test_data_read();
        for (int i = 0; i < 3; i++) begin
            drive(1, 8'h81, i < 2, 0, 8'h20, 8'h00, 0);
            total++;
            if (obs() !== expv()) $display("FAIL data_read cyc %0d got %h want %h", i, obs(), expv());
            else passed++;
            if (i == 0) begin
                total++;
                if ({cpu.dm_gnt, cpu.stall_if, mem_addr} !== {1'b1, 1'b1, 8'h20})
                    $display("FAIL data_grant got %h want %h", {cpu.dm_gnt, cpu.stall_if, mem_addr}, {1'b1, 1'b1, 8'h20});
                else passed++;
            end
            model_next();
        end
        total++;
        if ({cpu.dm_rvalid, cpu.dm_rdata, cpu.if_rvalid} !== {1'b1, 8'hAB, 1'b0})
            $display("FAIL data_return got %h want %h", {cpu.dm_rvalid, cpu.dm_rdata, cpu.if_rvalid}, {1'b1, 8'hAB, 1'b0});
        else passed++;
    endtask

    task automatic test_starvation();
        bit pat [8] = '{1, 1, 1, 0, 1, 1, 1, 0};
        drive(1, 8'h82, 0, 0, 8'h00, 8'h00, 0);
        total++;
        if (obs() !== expv()) $display("FAIL starve_prep got %h want %h", obs(), expv());
        else passed++;
        model_next();
        for (int i = 0; i < 8; i++) begin
            drive(1, 8'h82, 1, 0, 8'h21, 8'h00, 0);
            total++;
            if (obs() !== expv() || cpu.dm_gnt !== pat[i] || cpu.if_gnt !== !pat[i])
                $display("FAIL starvation cyc %0d got %h dm_gnt %b want %h dm_gnt %b", i, obs(), cpu.dm_gnt, expv(), pat[i]);
            else passed++;
            model_next();
        end
    endtask

    task automatic test_write();
        for (int i = 0; i < 2; i++) begin
            drive(0, 8'h00, i == 0, 1, 8'h30, 8'h5A, 0);
            total++;
            if (obs() !== expv() || mem_we !== (i == 0))
                $display("FAIL write cyc %0d got %h mem_we %b want %h", i, obs(), mem_we, expv());
            else passed++;
            model_next();
        end
        total++;
        if ({mem[8'h30], cpu.dm_rvalid} !== {8'h5A, 1'b0})
            $display("FAIL write_mem got %h want %h", {mem[8'h30], cpu.dm_rvalid}, {8'h5A, 1'b0});
        else passed++;
    endtask

    task automatic test_interrupt();
        bit is_t [11] = '{1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0};
        bit dr_t [11] = '{1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        int vcount = 0;
        for (int i = 0; i < 11; i++) begin
            drive(1, 8'h83, dr_t[i], 0, 8'h44, 8'h00, is_t[i]);
            vcount += int'(vec_valid === 1'b1 && vec_data === 8'h40);
            total++;
            if (obs() !== expv()) $display("FAIL interrupt cyc %0d got %h want %h", i, obs(), expv());
            else passed++;
            if (i == 1 || i == 3) begin
                total++;
                if ((i == 1 && cpu.dm_gnt !== 1'b1) || (i == 3 && mem_addr !== 8'h01))
                    $display("FAIL int_order cyc %0d got dm_gnt %b mem_addr %h", i, cpu.dm_gnt, mem_addr);
                else passed++;
            end
            model_next();
        end
        total++;
        if (vcount !== 2) $display("FAIL int_vec_count got %0d want 2", vcount);
        else passed++;
    endtask

    task automatic test_reset_mid();
        int vcount = 0;
        for (int i = 0; i < 4; i++) begin
            drive(1, 8'h84, 0, 0, 8'h00, 8'h00, i == 0);
            total++;
            if (obs() !== expv()) $display("FAIL mid_reset_pre cyc %0d got %h want %h", i, obs(), expv());
            else passed++;
            if (i < 3) model_next();
        end
        rst = 1; int_sig = 0; model_reset();
        for (int i = 0; i < 2; i++) begin
            if (i == 1) @(negedge clk);
            #1;
            total++;
            if ({cpu.if_gnt, cpu.dm_gnt, cpu.stall_if, mem_we, cpu.if_rvalid, cpu.dm_rvalid, vec_valid, vec_data, mem_addr} !== 23'h0)
                $display("FAIL mid_reset_outputs step %0d got %h want 0", i, {cpu.if_gnt, cpu.dm_gnt, cpu.stall_if, mem_we,
                         cpu.if_rvalid, cpu.dm_rvalid, vec_valid, vec_data, mem_addr});
            else passed++;
        end
        @(posedge clk); #1 rst = 0;
        for (int i = 0; i < 8; i++) begin
            drive(1, 8'h85, 0, 0, 8'h00, 8'h00, 0);
            vcount += int'(vec_valid === 1'b1);
            total++;
            if (obs() !== expv()) $display("FAIL mid_reset_reboot cyc %0d got %h want %h", i, obs(), expv());
            else passed++;
            model_next();
        end
        total++;
        if ({vcount, vec_data} !== {32'd1, 8'h10}) $display("FAIL reboot_vec got %0d/%h want 1/10", vcount, vec_data);
        else passed++;
    endtask

    task automatic test_random();
        bit ir = 0, dr = 0, dw = 0, is = 0, hi = 0, hd = 0;
        logic [7:0] ia = 0, da = 0, dd = 0;
        for (int i = 0; i < 600; i++) begin
            if (!hi) begin ir = $urandom_range(3) != 0; ia = 8'($urandom); end
            if (!hd) begin
                dr = $urandom_range(1) != 0; dw = $urandom_range(1) != 0;
                da = 8'($urandom); dd = 8'($urandom);
            end
            if ($urandom_range(7) == 0) is = !is;
            drive(ir, ia, dr, dw, da, dd, is);
            total++;
            if (obs() !== expv()) $display("FAIL random cyc %0d got %h want %h", i, obs(), expv());
            else passed++;
            hi = ir && !e_ig;
            hd = dr && !e_dg;
            model_next();
        end
    endtask

    initial begin
        test_reset();
        test_data_read();
        test_starvation();
        test_write();
        test_interrupt();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
